irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Parametrised multi-source interrupt controller; successor to the single `ei` line feeding the core's csr block.
- Aggregates N_SRC external sources through per-source gateways, prioritises them against a threshold, and drives one `ei` output into csr.
- Core identifies and retires interrupts via a claim/complete handshake; software configures it through a simple word-addressed config port.

Parameters:
N_SRC, 8, number of interrupt sources (1..31); source index i carries ID i+1, ID 0 = none
PRIO_W, 3, priority field width; priority 0 = source never wins
ID_W, 5, claim/complete ID width; must satisfy 2**ID_W > N_SRC

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
irq_src  input  N_SRC  raw interrupt sources
cfg_we  input  1  config write strobe
cfg_addr  input  8  config word address
cfg_wdata  input  32  config write data
cfg_rdata  output  32  config read data, combinational from cfg_addr
claim_req  input  1  one-cycle claim pulse from core
claim_valid  output  1  one-cycle pulse, claim_id valid
claim_id  output  ID_W  claimed ID (0 = nothing pending)
complete  input  1  one-cycle completion pulse
complete_id  input  ID_W  ID being completed
ei  output  1  external interrupt request to csr

Behaviour:
- Reset (clk edge with rst=1): enable, edge_mask, threshold, all priorities, pending, in_service, sampled-source flops cleared; ei=0, claim_valid=0, claim_id=0. rst mid-claim or mid-service discards all state.
- Register map (word addr):
  - 0x00 enable[N_SRC-1:0], RW.
  - 0x01 edge_mask, RW; 1 = rising-edge, 0 = level.
  - 0x02 threshold[PRIO_W-1:0], RW.
  - 0x03 pending, RO.
  - 0x04 in_service, RO.
  - 0x08+i priority of source i, RW, i<N_SRC.
  - Writes are masked to field width. Unmapped reads return 0; unmapped writes are ignored.
- Sampling: `s` = registered irq_src, 1 cycle; `s_d` = a further delay of `s`, used for edge detection.
- Gateway per source i:
  - Set pending[i] when !in_service[i] && !pending[i] && (edge_mask[i] ? (s[i] && !s_d[i]) : s[i]).
  - Edges arriving while pending or in_service are dropped (no counting).
- Arbitration (combinational):
  - Candidates: pending & enable with prio > threshold.
  - Winner is the highest priority; ties go to the lowest index.
  - best_id = index+1, or 0 if there are no candidates.
- ei is registered: ei <= (best_id != 0).
- Latency: irq_src rise at edge t → s at t+1 → pending at t+2 → ei at t+3.
- Claim: on claim_req, claim_id <= best_id and claim_valid <= 1 for one cycle. If best_id != 0, pending[best_id-1] is cleared and in_service[best_id-1] is set on the same edge. claim_req with best_id==0 returns ID 0 and changes no state.
- Complete:
  - If complete_id is in 1..N_SRC and in_service[complete_id-1]=1, clear it. Otherwise ignore.
  - A level source still asserted re-pends on the next gateway evaluation.
- Simultaneous claim and complete in the same cycle are both applied; they never target the same ID.
- Simultaneous gateway set and claim of a different ID are both applied.
- Disabling a pending source leaves pending set, but the source no longer wins.
- Config changes (priority, threshold, enable) take effect on arbitration the next cycle.

Optional Feature:
- Macro IRQ_CTRL_SYNC_EN.
- Defined: irq_src passes through a 2-flop synchroniser (reset to 0) before `s`; all source-to-pending and source-to-ei latencies grow by 2 cycles (ei at t+5).
- Undefined: no synchroniser; sources must be synchronous to clk; latencies as above.

Test Plan:
- Reset, then enable=0x01, prio[0]=1, threshold=0, level src[0]=1 at cycle t → ei=1 at t+3; claim → claim_id=1, claim_valid one cycle, pending[0]=0, in_service[0]=1.
- Sources 2 and 5 pending, prio[2]=3, prio[5]=3, threshold=0 → claim_id=3 (lowest index). Set prio[5]=4 → next claim_id=6.
- threshold=3, prio[0]=3, src[0] pending → ei stays 0 and claim returns 0. Set threshold=2 → ei=1 one cycle later.
- Edge source, one-cycle pulse while in_service → pulse dropped. After complete_id=1, a new pulse → pending[0]=1. Level source held high through complete → re-pends.
- complete_id=0, complete_id=N_SRC+1, and complete_id of a source not in service → no state change. claim_req with nothing pending → claim_id=0, claim_valid=1.
- rst asserted while in_service=0x3 and ei=1 → next cycle all registers 0 and ei=0. With IRQ_CTRL_SYNC_EN defined, ei asserts at t+5.

Source files
------------

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: per-source gateways, priority/threshold arbitration,
// claim/complete handshake and a word-addressed config port. IRQ_CTRL_SYNC_EN adds a 2-flop input synchroniser.
module irq_ctrl #(
    parameter int unsigned N_SRC  = 8,
    parameter int unsigned PRIO_W = 3,
    parameter int unsigned ID_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_src,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    input  logic              claim_req,
    output logic              claim_valid,
    output logic [ID_W-1:0]   claim_id,
    input  logic              complete,
    input  logic [ID_W-1:0]   complete_id,
    output logic              ei
);

    localparam int unsigned DATA_W = 32;
    localparam logic [7:0] ADDR_ENABLE    = 8'h00;
    localparam logic [7:0] ADDR_EDGE      = 8'h01;
    localparam logic [7:0] ADDR_THRESHOLD = 8'h02;
    localparam logic [7:0] ADDR_PENDING   = 8'h03;
    localparam logic [7:0] ADDR_IN_SERV   = 8'h04;
    localparam logic [7:0] ADDR_PRIO_BASE = 8'h08;

    logic [N_SRC-1:0]  enable;
    logic [N_SRC-1:0]  edge_mask;
    logic [PRIO_W-1:0] threshold;
    logic [PRIO_W-1:0] prio [N_SRC];
    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  in_service;
    logic [N_SRC-1:0]  s;
    logic [N_SRC-1:0]  s_d;
    logic [N_SRC-1:0]  src_in;

    logic [N_SRC-1:0]  gw_set;
    logic [N_SRC-1:0]  claim_mask;
    logic [N_SRC-1:0]  cmpl_mask;
    logic [PRIO_W-1:0] best_prio;
    logic [ID_W-1:0]   best_id;
    logic              unused_wdata;

    assign unused_wdata = ^cfg_wdata;

`ifdef IRQ_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync_q1;
    logic [N_SRC-1:0] sync_q2;

    // Two-flop synchroniser for asynchronous sources
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src;
            sync_q2 <= sync_q1;
        end
    end

    assign src_in = sync_q2;
`else
    assign src_in = irq_src;
`endif

    // Source sampling; s_d exists only for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= '0;
            s_d <= '0;
        end else begin
            s   <= src_in;
            s_d <= s;
        end
    end

    // Gateway: one request at a time per source, later edges while busy are dropped
    assign gw_set = ~in_service & ~pending &
                    ((edge_mask & s & ~s_d) | (~edge_mask & s));

    // Strict '>' starting from threshold gives prio > threshold and lowest index on ties
    always_comb begin
        best_prio = threshold;
        best_id   = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (pending[i] && enable[i] && (prio[i] > best_prio)) begin
                best_prio = prio[i];
                best_id   = ID_W'(i + 1);
            end
        end
    end

    always_comb begin
        claim_mask = '0;
        cmpl_mask  = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            claim_mask[i] = claim_req && (best_id == ID_W'(i + 1));
            cmpl_mask[i]  = complete && (complete_id == ID_W'(i + 1));
        end
    end

    // Interrupt state, handshake outputs and config registers
    always_ff @(posedge clk) begin
        if (rst) begin
            enable      <= '0;
            edge_mask   <= '0;
            threshold   <= '0;
            pending     <= '0;
            in_service  <= '0;
            ei          <= 1'b0;
            claim_valid <= 1'b0;
            claim_id    <= '0;
            for (int i = 0; i < int'(N_SRC); i++) begin
                prio[i] <= '0;
            end
        end else begin
            pending     <= (pending | gw_set) & ~claim_mask;
            in_service  <= (in_service & ~cmpl_mask) | claim_mask;
            ei          <= (best_id != '0);
            claim_valid <= claim_req;
            if (claim_req) begin
                claim_id <= best_id;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_ENABLE:    enable    <= cfg_wdata[N_SRC-1:0];
                    ADDR_EDGE:      edge_mask <= cfg_wdata[N_SRC-1:0];
                    ADDR_THRESHOLD: threshold <= cfg_wdata[PRIO_W-1:0];
                    default: ;
                endcase
            end
            for (int i = 0; i < int'(N_SRC); i++) begin
                if (cfg_we && (cfg_addr == (ADDR_PRIO_BASE + 8'(i)))) begin
                    prio[i] <= cfg_wdata[PRIO_W-1:0];
                end
            end
        end
    end

    // Combinational config read; unmapped addresses read as zero
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_ENABLE:    cfg_rdata = DATA_W'(enable);
            ADDR_EDGE:      cfg_rdata = DATA_W'(edge_mask);
            ADDR_THRESHOLD: cfg_rdata = DATA_W'(threshold);
            ADDR_PENDING:   cfg_rdata = DATA_W'(pending);
            ADDR_IN_SERV:   cfg_rdata = DATA_W'(in_service);
            default: ;
        endcase
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (cfg_addr == (ADDR_PRIO_BASE + 8'(i))) begin
                cfg_rdata = DATA_W'(prio[i]);
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboarded bench for irq_ctrl: claims push expected IDs, a monitor checks each claim_valid pulse.
module tb_irq_ctrl;

    localparam int unsigned N_SRC  = 8;
    localparam int unsigned PRIO_W = 3;
    localparam int unsigned ID_W   = 5;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic              clk;
    logic              rst;
    logic [N_SRC-1:0]  irq_src;
    logic              cfg_we;
    logic [7:0]        cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;
    logic              claim_req;
    logic              claim_valid;
    logic [ID_W-1:0]   claim_id;
    logic              complete;
    logic [ID_W-1:0]   complete_id;
    logic              ei;

    int n_vec = 0;
    int n_err = 0;
    logic [ID_W-1:0] exp_q[$];

    irq_ctrl #(.N_SRC(N_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .claim_req(claim_req), .claim_valid(claim_valid), .claim_id(claim_id),
        .complete(complete), .complete_id(complete_id), .ei(ei)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
        cfg_addr = a;
        #1;
        check(name, cfg_rdata, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic claim(input logic [ID_W-1:0] exp_id);
        exp_q.push_back(exp_id);
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
    endtask

    task automatic cmpl(input logic [ID_W-1:0] id);
        complete = 1'b1; complete_id = id;
        tick();
        complete = 1'b0; complete_id = '0;
    endtask

    // Monitor: every claim_valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (claim_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL claim_unexpected: got id %0d expected no claim", claim_id);
            end else begin
                logic [ID_W-1:0] e;
                e = exp_q.pop_front();
                if (claim_id !== e) begin
                    n_err++;
                    $display("FAIL claim_id: got %0d expected %0d", claim_id, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        claim_req = 1'b0; complete = 1'b0; complete_id = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_ei", 32'(ei), 0);
        check("rst_claim_valid", 32'(claim_valid), 0);
        check("rst_claim_id", 32'(claim_id), 0);
        rd(8'h00, 0, "rst_enable");
        rd(8'h04, 0, "rst_in_service");

        // unmapped and read-only writes are ignored; field masking
        wr(8'h30, 32'hFFFF_FFFF);
        rd(8'h30, 0, "unmapped_30");
        wr(8'h10, 32'hFFFF_FFFF);
        rd(8'h10, 0, "unmapped_prio_8");
        wr(8'h03, 32'hFF);
        rd(8'h03, 0, "pending_ro");

        // level source 0: latency and claim
        wr(8'h00, 1);
        wr(8'h08, 1);
        irq_src = 8'h01;
        repeat (1 + S) tick();
        rd(8'h03, 0, "lat_pending_early");
        tick();
        rd(8'h03, 1, "lat_pending");
        check("lat_ei_early", 32'(ei), 0);
        tick();
        check("lat_ei", 32'(ei), 1);
        claim(1);
        rd(8'h03, 0, "claim_pending_clr");
        rd(8'h04, 1, "claim_in_service");
        tick();
        check("claim_ei_drop", 32'(ei), 0);

        // invalid completes change nothing
        cmpl(0);
        cmpl(5'(N_SRC + 1));
        cmpl(2);
        rd(8'h04, 1, "bad_cmpl_in_service");
        rd(8'h03, 0, "bad_cmpl_pending");
        // level source held high re-pends after complete
        cmpl(1);
        rd(8'h04, 0, "cmpl_in_service");
        tick();
        rd(8'h03, 1, "level_repend");
        tick();
        claim(1);
        irq_src = '0;
        repeat (3 + S) tick();
        cmpl(1);
        tick();
        rd(8'h04, 0, "l_clean_is");
        rd(8'h03, 0, "l_clean_pend");

        claim(0);
        tick();
        rd(8'h04, 0, "empty_claim_is");

        // ties go to lowest index, then higher priority wins
        wr(8'h00, 32'h24);
        wr(8'h0A, 3);
        wr(8'h0D, 3);
        irq_src = 8'h24;
        repeat (3 + S) tick();
        rd(8'h03, 32'h24, "tie_pending");
        claim(3);
        cmpl(3);
        tick();
        rd(8'h03, 32'h24, "tie_repend");
        wr(8'h0D, 32'h0000_00FC);
        rd(8'h0D, 4, "prio_mask");
        claim(6);
        rd(8'h03, 32'h04, "prio_pending");
        rd(8'h04, 32'h20, "prio_in_service");
        claim(3);
        rd(8'h04, 32'h24, "both_in_service");
        irq_src = '0;
        repeat (3 + S) tick();
        cmpl(6);
        cmpl(3);
        rd(8'h04, 0, "tie_clean");

        // threshold gating, then enable gating
        wr(8'h00, 1);
        wr(8'h08, 3);
        wr(8'h02, 3);
        irq_src = 8'h01;
        repeat (3 + S) tick();
        rd(8'h03, 1, "thr_pending");
        check("thr_ei_blocked", 32'(ei), 0);
        claim(0);
        rd(8'h03, 1, "thr_pending_kept");
        rd(8'h04, 0, "thr_no_service");
        wr(8'h02, 32'hFFFF_FFFA);
        check("thr_ei_same_cycle", 32'(ei), 0);
        rd(8'h02, 2, "thr_mask");
        tick();
        check("thr_ei_next", 32'(ei), 1);
        wr(8'h00, 0);
        tick();
        check("dis_ei", 32'(ei), 0);
        rd(8'h03, 1, "dis_pending_kept");
        claim(0);
        wr(8'h00, 1);
        claim(1);
        irq_src = '0;
        repeat (3 + S) tick();
        cmpl(1);
        wr(8'h02, 0);

        // edge source: pulses while in service are dropped
        wr(8'h01, 1);
        irq_src = 8'h01; tick(); irq_src = '0;
        repeat (3 + S) tick();
        rd(8'h03, 1, "edge_pending");
        claim(1);
        rd(8'h04, 1, "edge_in_service");
        irq_src = 8'h01; tick(); irq_src = '0;
        repeat (3 + S) tick();
        rd(8'h03, 0, "edge_dropped");
        cmpl(1);
        repeat (2) tick();
        rd(8'h03, 0, "edge_no_repend");
        irq_src = 8'h01; tick(); irq_src = '0;
        repeat (3 + S) tick();
        rd(8'h03, 1, "edge_new_pulse");
        claim(1);
        cmpl(1);
        wr(8'h01, 0);

        // reset with sources in service and ei high
        wr(8'h00, 32'h07);
        wr(8'h08, 1);
        wr(8'h09, 1);
        wr(8'h0A, 1);
        irq_src = 8'h07;
        repeat (3 + S) tick();
        claim(1);
        claim(2);
        tick();
        rd(8'h04, 3, "pre_rst_in_service");
        rd(8'h03, 4, "pre_rst_pending");
        check("pre_rst_ei", 32'(ei), 1);
        rst = 1'b1;
        tick();
        check("post_rst_ei", 32'(ei), 0);
        check("post_rst_claim_valid", 32'(claim_valid), 0);
        check("post_rst_claim_id", 32'(claim_id), 0);
        rd(8'h03, 0, "post_rst_pending");
        rd(8'h04, 0, "post_rst_in_service");
        rd(8'h00, 0, "post_rst_enable");
        rd(8'h09, 0, "post_rst_prio");
        rst = 1'b0;
        irq_src = '0;

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("scoreboard_drain", 32'(exp_q.size()), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
